// File: rtl/apb_slave_txn_capture.sv
// APB slave-side transaction capture: tracks transfer phases and queues one record per completed transfer.
// Define APB_SLAVE_TXN_CAPTURE_PROTO_CHECK_EN to compile in the protocol checker (proto_err / proto_err_code).
//
// state     | meaning
// ST_IDLE   | no transfer in flight; waiting for a setup-phase sample
// ST_SETUP  | setup sampled and request fields latched; expecting the first access-phase sample
// ST_ACCESS | access phase extended by pready=0; counting wait states
module apb_slave_txn_capture #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                              pclk,
   input  logic                              preset_n,
   input  logic                              psel,
   input  logic                              penable,
   input  logic                              pwrite,
   input  logic [ADDR_WIDTH-1:0]             paddr,
   input  logic [DATA_WIDTH-1:0]             pwdata,
   input  logic [DATA_WIDTH/8-1:0]           pstrb,
   input  logic [2:0]                        pprot,
   input  logic                              pready,
   input  logic [DATA_WIDTH-1:0]             prdata,
   input  logic                              pslverr,
   output logic                              txn_valid,
   input  logic                              txn_ready,
   output logic                              txn_write,
   output logic [ADDR_WIDTH-1:0]             txn_addr,
   output logic [DATA_WIDTH-1:0]             txn_data,
   output logic [DATA_WIDTH/8-1:0]           txn_strb,
   output logic [2:0]                        txn_prot,
   output logic                              txn_slverr,
   output logic [7:0]                        txn_wait,
   output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
   output logic                              overflow,
   output logic                              proto_err,
   output logic [1:0]                        proto_err_code
);

   localparam int SW = DATA_WIDTH / 8;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

`ifdef APB_SLAVE_TXN_CAPTURE_PROTO_CHECK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

   typedef struct packed {
      logic                  write;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
      logic [SW-1:0]         strb;
      logic [2:0]            prot;
      logic                  slverr;
      logic [7:0]            waits;
   } rec_t;

   state_t                state_q, state_d;
   logic                  lat_write_q, lat_write_d;
   logic [ADDR_WIDTH-1:0] lat_addr_q, lat_addr_d;
   logic [DATA_WIDTH-1:0] lat_wdata_q, lat_wdata_d;
   logic [SW-1:0]         lat_strb_q, lat_strb_d;
   logic [2:0]            lat_prot_q, lat_prot_d;
   logic [7:0]            wait_q, wait_d;
   logic                  proto_err_q, proto_err_d;
   logic [1:0]            proto_code_q, proto_code_d;

   rec_t                  mem_q [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d, count_after_pop;
   rec_t                  head_q, head_d;
   logic                  valid_q, valid_d;
   logic                  overflow_q, overflow_d;

   logic                  push, pop, accept, full, fields_changed;
   logic                  viol;
   logic [1:0]            viol_code;
   rec_t                  push_rec;

   assign fields_changed = (paddr != lat_addr_q) || (pwrite != lat_write_q) ||
                           (pwdata != lat_wdata_q) || (pstrb != lat_strb_q) ||
                           (pprot != lat_prot_q);

   // Phase tracking; state_q is the phase of the previous bus sample.
   always_comb begin
      state_d     = state_q;
      lat_write_d = lat_write_q;
      lat_addr_d  = lat_addr_q;
      lat_wdata_d = lat_wdata_q;
      lat_strb_d  = lat_strb_q;
      lat_prot_d  = lat_prot_q;
      wait_d      = wait_q;
      push        = 1'b0;
      push_rec    = '0;
      viol        = 1'b0;
      viol_code   = 2'd0;
      case (state_q)
         ST_IDLE: begin
            if (CHK_EN && psel && penable) begin
               viol      = 1'b1;
               viol_code = 2'd1;
            end else if (psel && !penable) begin
               state_d     = ST_SETUP;
               lat_write_d = pwrite;
               lat_addr_d  = paddr;
               lat_wdata_d = pwdata;
               lat_strb_d  = pstrb;
               lat_prot_d  = pprot;
               wait_d      = 8'd0;
            end
         end
         ST_SETUP, ST_ACCESS: begin
            if (!(psel && penable)) begin
               state_d = ST_IDLE;
               if (CHK_EN && (state_q == ST_ACCESS) && !psel) begin
                  viol      = 1'b1;
                  viol_code = 2'd3;
               end
            end else if (CHK_EN && (state_q == ST_ACCESS) && fields_changed) begin
               state_d   = ST_IDLE;
               viol      = 1'b1;
               viol_code = 2'd2;
            end else if (pready) begin
               state_d         = ST_IDLE;
               push            = 1'b1;
               push_rec.write  = lat_write_q;
               push_rec.addr   = lat_addr_q;
               push_rec.data   = lat_write_q ? lat_wdata_q : prdata;
               push_rec.strb   = lat_write_q ? lat_strb_q : '0;
               push_rec.prot   = lat_prot_q;
               push_rec.slverr = pslverr;
               push_rec.waits  = wait_q;
            end else begin
               state_d = ST_ACCESS;
               if (wait_q != 8'hFF) wait_d = wait_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      proto_err_d  = viol;
      proto_code_d = viol ? viol_code : proto_code_q;
   end

   // Record FIFO with a registered head; the head is refilled on the same edge as any pop.
   always_comb begin
      pop             = valid_q && txn_ready;
      full            = (count_q == FULL_CNT);
      accept          = push && (!full || pop);
      overflow_d      = overflow_q || (push && full && !pop);
      count_after_pop = count_q - CW'(pop);
      count_d         = count_after_pop + CW'(accept);
      rd_ptr_d        = rd_ptr_q + PW'(pop);
      wr_ptr_d        = wr_ptr_q + PW'(accept);
      valid_d         = (count_d != '0);
      if (count_d == '0)              head_d = '0;
      else if (count_after_pop == '0) head_d = push_rec;
      else                            head_d = mem_q[rd_ptr_d];
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_q      <= ST_IDLE;
         lat_write_q  <= 1'b0;
         lat_addr_q   <= '0;
         lat_wdata_q  <= '0;
         lat_strb_q   <= '0;
         lat_prot_q   <= '0;
         wait_q       <= 8'd0;
         proto_err_q  <= 1'b0;
         proto_code_q <= 2'd0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         head_q       <= '0;
         valid_q      <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         lat_write_q  <= lat_write_d;
         lat_addr_q   <= lat_addr_d;
         lat_wdata_q  <= lat_wdata_d;
         lat_strb_q   <= lat_strb_d;
         lat_prot_q   <= lat_prot_d;
         wait_q       <= wait_d;
         proto_err_q  <= proto_err_d;
         proto_code_q <= proto_code_d;
         if (accept) mem_q[wr_ptr_q] <= push_rec;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         head_q       <= head_d;
         valid_q      <= valid_d;
         overflow_q   <= overflow_d;
      end
   end

   assign txn_valid      = valid_q;
   assign txn_write      = head_q.write;
   assign txn_addr       = head_q.addr;
   assign txn_data       = head_q.data;
   assign txn_strb       = head_q.strb;
   assign txn_prot       = head_q.prot;
   assign txn_slverr     = head_q.slverr;
   assign txn_wait       = head_q.waits;
   assign fifo_count     = count_q;
   assign overflow       = overflow_q;
   assign proto_err      = proto_err_q;
   assign proto_err_code = proto_code_q;

endmodule

// File: tb/tb_apb_slave_txn_capture.sv
// Randomized bench for apb_slave_txn_capture: transaction-level queue model plus directed literal checks.
module tb_apb_slave_txn_capture;

   localparam int DEPTH = 4;

`ifdef APB_SLAVE_TXN_CAPTURE_PROTO_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        pclk = 1'b0;
   logic        preset_n = 1'b0;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [31:0] paddr = '0, pwdata = '0, prdata = '0;
   logic [3:0]  pstrb = '0;
   logic [2:0]  pprot = '0;
   logic        pready = 1'b0, pslverr = 1'b0;
   logic        txn_valid, txn_ready = 1'b0, txn_write, txn_slverr;
   logic [31:0] txn_addr, txn_data;
   logic [3:0]  txn_strb;
   logic [2:0]  txn_prot;
   logic [7:0]  txn_wait;
   logic [2:0]  fifo_count;
   logic        overflow, proto_err;
   logic [1:0]  proto_err_code;

   apb_slave_txn_capture #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
      .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .pready(pready),
      .prdata(prdata), .pslverr(pslverr), .txn_valid(txn_valid), .txn_ready(txn_ready),
      .txn_write(txn_write), .txn_addr(txn_addr), .txn_data(txn_data), .txn_strb(txn_strb),
      .txn_prot(txn_prot), .txn_slverr(txn_slverr), .txn_wait(txn_wait),
      .fifo_count(fifo_count), .overflow(overflow), .proto_err(proto_err),
      .proto_err_code(proto_err_code));

   always #5 pclk = ~pclk;

   typedef struct {
      bit        wr;
      bit [31:0] addr;
      bit [31:0] data;
      bit [3:0]  strb;
      bit [2:0]  prot;
      bit        err;
      bit [7:0]  waits;
   } rec_t;

   rec_t        mq[$];
   bit [31:0]   popped[$];
   rec_t        exp_rec;
   bit          exp_push = 1'b0, exp_err = 1'b0;
   bit [1:0]    exp_code = 2'd0;
   bit          m_ovf = 1'b0, m_perr = 1'b0;
   bit [1:0]    m_code = 2'd0;
   int          ready_mode = 1;
   int          n_total = 0, n_pass = 0;
   bit [31:0]   addrs[5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   // Queue model: pop on valid&ready, then accept the new record if a slot is free.
   always @(posedge pclk) begin
      if (!preset_n) begin
         mq.delete();
         m_ovf  = 1'b0;
         m_perr = 1'b0;
         m_code = 2'd0;
      end else begin
         if (txn_valid && txn_ready) popped.push_back(txn_addr);
         if (mq.size() > 0 && txn_ready) void'(mq.pop_front());
         if (exp_push) begin
            if (mq.size() < DEPTH) mq.push_back(exp_rec);
            else m_ovf = 1'b1;
         end
         m_perr = exp_err;
         if (exp_err) m_code = exp_code;
      end
      #1;
      chk("valid", 64'(txn_valid), 64'(mq.size() > 0));
      chk("count", 64'(fifo_count), 64'(mq.size()));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("proto_err", 64'(proto_err), 64'(m_perr));
      chk("proto_code", 64'(proto_err_code), 64'(m_code));
      if (mq.size() > 0) begin
         chk("head_write", 64'(txn_write), 64'(mq[0].wr));
         chk("head_addr", 64'(txn_addr), 64'(mq[0].addr));
         chk("head_data", 64'(txn_data), 64'(mq[0].data));
         chk("head_strb", 64'(txn_strb), 64'(mq[0].strb));
         chk("head_prot", 64'(txn_prot), 64'(mq[0].prot));
         chk("head_slverr", 64'(txn_slverr), 64'(mq[0].err));
         chk("head_wait", 64'(txn_wait), 64'(mq[0].waits));
      end
   end

   task automatic step(input bit done);
      case (ready_mode)
         0:       txn_ready = 1'($urandom_range(0, 1));
         1:       txn_ready = 1'b1;
         2:       txn_ready = 1'b0;
         default: txn_ready = done;
      endcase
      @(negedge pclk);
      exp_push = 1'b0;
      exp_err  = 1'b0;
   endtask

   task automatic idle();
      psel = 1'b0; penable = 1'b0; pready = 1'b0;
      paddr = $urandom; pwdata = $urandom; prdata = $urandom;
      step(1'b0);
   endtask

   task automatic do_xfer(input bit wr, input bit [31:0] a, input bit [31:0] wd, input bit [3:0] sb,
                          input bit [2:0] pr, input bit [31:0] rd, input bit se, input int waits);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = sb; pprot = pr;
      pready = 1'($urandom_range(0, 1)); prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
      step(1'b0);
      penable = 1'b1;
      repeat (waits) begin
         pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
         step(1'b0);
      end
      pready = 1'b1; prdata = rd; pslverr = se;
      exp_rec.wr    = wr;
      exp_rec.addr  = a;
      exp_rec.data  = wr ? wd : rd;
      exp_rec.strb  = wr ? sb : 4'h0;
      exp_rec.prot  = pr;
      exp_rec.err   = se;
      exp_rec.waits = (waits > 255) ? 8'd255 : 8'(waits);
      exp_push = 1'b1;
      step(1'b1);
   endtask

   task automatic do_reset();
      psel = 1'b0; penable = 1'b0; pready = 1'b0;
      preset_n = 1'b0;
      step(1'b0);
      step(1'b0);
      preset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_total);
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge pclk);
      @(negedge pclk);
      chk("rst_valid", 64'(txn_valid), 64'd0);
      chk("rst_count", 64'(fifo_count), 64'd0);
      chk("rst_addr", 64'(txn_addr), 64'd0);
      preset_n = 1'b1;
      idle();

      // Single write, zero waits, monitor always ready.
      ready_mode = 1;
      do_xfer(1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, 3'd0, 32'h0, 1'b0, 0);
      chk("w_valid", 64'(txn_valid), 64'd1);
      chk("w_write", 64'(txn_write), 64'd1);
      chk("w_addr", 64'(txn_addr), 64'h10);
      chk("w_data", 64'(txn_data), 64'hA5A5A5A5);
      chk("w_strb", 64'(txn_strb), 64'hF);
      chk("w_wait", 64'(txn_wait), 64'd0);
      chk("w_slverr", 64'(txn_slverr), 64'd0);
      idle();
      chk("w_valid_1cyc", 64'(txn_valid), 64'd0);

      // Read with three wait states and an error response.
      do_xfer(1'b0, 32'h20, 32'hFFFF0000, 4'hF, 3'd2, 32'h1234, 1'b1, 3);
      chk("r_write", 64'(txn_write), 64'd0);
      chk("r_addr", 64'(txn_addr), 64'h20);
      chk("r_data", 64'(txn_data), 64'h1234);
      chk("r_strb", 64'(txn_strb), 64'd0);
      chk("r_wait", 64'(txn_wait), 64'd3);
      chk("r_slverr", 64'(txn_slverr), 64'd1);
      chk("r_prot", 64'(txn_prot), 64'd2);
      idle();

      // Five back-to-back writes with the monitor stalled: fifth is dropped.
      ready_mode = 2;
      for (int i = 0; i < 5; i++) begin
         addrs[i] = 32'h100 + 32'(4 * i);
         do_xfer(1'b1, addrs[i], $urandom, 4'($urandom), 3'($urandom), 32'h0, 1'b0, i % 2);
      end
      chk("ovf_count", 64'(fifo_count), 64'd4);
      chk("ovf_flag", 64'(overflow), 64'd1);
      popped.delete();
      ready_mode = 1;
      repeat (6) idle();
      chk("ovf_drained", 64'(popped.size()), 64'd4);
      for (int i = 0; i < 4; i++) chk("ovf_order", 64'(popped[i]), 64'(addrs[i]));
      do_reset();
      chk("ovf_cleared", 64'(overflow), 64'd0);

      // Full FIFO with a pop and a completing transfer on the same edge.
      ready_mode = 2;
      for (int i = 0; i < 4; i++) begin
         addrs[i] = 32'h200 + 32'(4 * i);
         do_xfer(1'b1, addrs[i], $urandom, 4'hF, 3'd1, 32'h0, 1'b0, 0);
      end
      popped.delete();
      ready_mode = 3;
      addrs[4] = 32'h2FC;
      do_xfer(1'b1, addrs[4], 32'hDEADBEEF, 4'h3, 3'd1, 32'h0, 1'b0, 1);
      chk("fullpop_count", 64'(fifo_count), 64'd4);
      chk("fullpop_ovf", 64'(overflow), 64'd0);
      ready_mode = 1;
      repeat (6) idle();
      chk("fullpop_drained", 64'(popped.size()), 64'd5);
      chk("fullpop_first", 64'(popped[0]), 64'h200);
      chk("fullpop_last", 64'(popped[4]), 64'h2FC);

      // Address changes during a wait state.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h40; pwdata = 32'h0BAD0BAD;
      pstrb = 4'hF; pprot = 3'd0;
      step(1'b0);
      penable = 1'b1; pready = 1'b0;
      step(1'b0);
      paddr = 32'h44;
      exp_err = CHK; exp_code = 2'd2;
      step(1'b0);
      chk("v2_pulse", 64'(proto_err), 64'(CHK));
      chk("v2_code", 64'(proto_err_code), CHK ? 64'd2 : 64'd0);
      if (CHK) begin
         idle();
      end else begin
         pready = 1'b1;
         exp_rec.wr = 1'b1; exp_rec.addr = 32'h40; exp_rec.data = 32'h0BAD0BAD; exp_rec.strb = 4'hF;
         exp_rec.prot = 3'd0; exp_rec.err = pslverr; exp_rec.waits = 8'd2;
         exp_push = 1'b1;
         step(1'b1);
         idle();
      end
      chk("v2_pulse_end", 64'(proto_err), 64'd0);

      // psel dropped before pready.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h50;
      step(1'b0);
      penable = 1'b1; pready = 1'b0;
      step(1'b0);
      psel = 1'b0; penable = 1'b0;
      exp_err = CHK; exp_code = 2'd3;
      step(1'b0);
      chk("v3_pulse", 64'(proto_err), 64'(CHK));
      chk("v3_code", 64'(proto_err_code), CHK ? 64'd3 : 64'd0);
      idle();
      chk("v3_pulse_end", 64'(proto_err), 64'd0);
      chk("v3_code_hold", 64'(proto_err_code), CHK ? 64'd3 : 64'd0);
      chk("v3_nopush", 64'(fifo_count), 64'd0);

      // Wait counter saturation.
      do_xfer(1'b0, 32'h80, 32'h0, 4'h0, 3'd7, 32'h55AA55AA, 1'b0, 258);
      chk("sat_wait", 64'(txn_wait), 64'd255);
      idle();

      // Reset during ACCESS with two records queued.
      ready_mode = 2;
      do_xfer(1'b1, 32'h300, 32'h11111111, 4'hF, 3'd0, 32'h0, 1'b0, 0);
      idle();
      do_xfer(1'b1, 32'h304, 32'h22222222, 4'hF, 3'd0, 32'h0, 1'b0, 1);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h308;
      step(1'b0);
      penable = 1'b1; pready = 1'b0;
      step(1'b0);
      chk("pre_rst_count", 64'(fifo_count), 64'd2);
      #2 preset_n = 1'b0;
      #1;
      chk("arst_valid", 64'(txn_valid), 64'd0);
      chk("arst_count", 64'(fifo_count), 64'd0);
      chk("arst_addr", 64'(txn_addr), 64'd0);
      chk("arst_data", 64'(txn_data), 64'd0);
      chk("arst_write", 64'(txn_write), 64'd0);
      chk("arst_strb", 64'(txn_strb), 64'd0);
      psel = 1'b0; penable = 1'b0;
      step(1'b0);
      step(1'b0);
      preset_n = 1'b1;
      ready_mode = 1;
      do_xfer(1'b0, 32'h70, 32'h0, 4'hF, 3'd5, 32'hCAFE0001, 1'b0, 2);
      chk("post_rst_addr", 64'(txn_addr), 64'h70);
      chk("post_rst_data", 64'(txn_data), 64'hCAFE0001);
      chk("post_rst_wait", 64'(txn_wait), 64'd2);
      chk("post_rst_count", 64'(fifo_count), 64'd1);
      idle();

      // Randomized traffic with a randomly stalling monitor.
      ready_mode = 0;
      for (int n = 0; n < 300; n++) begin
         int w;
         w = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 12)) : int'($urandom_range(0, 3));
         do_xfer(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), 3'($urandom),
                 $urandom, 1'($urandom_range(0, 1)), w);
         if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) idle();
      end
      ready_mode = 1;
      repeat (8) idle();
      chk("final_empty", 64'(fifo_count), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
